// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole scorer.
package mole_pkg;

  localparam int unsigned DEFAULT_NUM_HOLES = 8;

  typedef enum logic [1:0] {LANE_DOWN, LANE_UP, LANE_WHACKED} lane_state_t;
  typedef enum logic [1:0] {G_IDLE, G_PLAY, G_OVER} game_state_t;

  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max);
    return (a + b > max) ? max : a + b;
  endfunction

endpackage

// File: rtl/mole_lane.sv
// One hole: key synchronizer, rising-edge press detect and DOWN/UP/WHACKED tracking.
// Optional whiff output exists only when MOLE_WHIFF_PENALTY_EN is defined.
module mole_lane
  import mole_pkg::*;
(
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic play,
  input  logic load,
  input  logic ctrl,
  input  logic key,
  output logic hit,
  output logic escape,
`ifdef MOLE_WHIFF_PENALTY_EN
  output logic whiff,
`endif
  output logic visible
);

  logic s1, s2, s3, press, take;
  lane_state_t state, state_d;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= key;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press = s2 & ~s3;
  assign take  = press & play;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= LANE_DOWN;
    else         state <= state_d;
  end

  // A hit on the cycle ctrl falls wins and drops straight to DOWN.
  always_comb begin
    state_d = state;
    if (load) begin
      state_d = ctrl ? LANE_UP : LANE_DOWN;
    end else begin
      case (state)
        LANE_DOWN:    if (ctrl) state_d = LANE_UP;
        LANE_UP: begin
          if (take)       state_d = ctrl ? LANE_WHACKED : LANE_DOWN;
          else if (!ctrl) state_d = LANE_DOWN;
        end
        LANE_WHACKED: if (!ctrl) state_d = LANE_DOWN;
        default:      state_d = LANE_DOWN;
      endcase
    end
  end

  always_comb begin
    hit     = (state == LANE_UP) & take;
    escape  = (state == LANE_UP) & ~ctrl & ~press & play;
    visible = (state == LANE_UP) | ((state == LANE_DOWN) & ctrl);
`ifdef MOLE_WHIFF_PENALTY_EN
    whiff   = (state == LANE_DOWN) & ~ctrl & take;
`endif
  end

endmodule

// File: rtl/mole_hit_scorer.sv
// Whack-a-mole game timer and scorer fed by the mole generator ctrl bus.
// Define MOLE_WHIFF_PENALTY_EN to subtract presses on empty holes from the score.
module mole_hit_scorer
  import mole_pkg::*;
#(
  parameter int unsigned NUM_HOLES    = DEFAULT_NUM_HOLES,
  parameter int unsigned SCORE_W      = 8,
  parameter int unsigned GAME_SECONDS = 60
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 tick,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] ctrl,
  input  logic [NUM_HOLES-1:0] key,
  output logic [NUM_HOLES-1:0] visible,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic [7:0]           time_left,
  output logic                 playing,
  output logic                 game_over,
  output logic                 hit_pulse
);

  localparam int unsigned CNT_W     = $clog2(NUM_HOLES + 1);
  localparam int unsigned SCORE_MAX = (2 ** SCORE_W) - 1;

  game_state_t gstate, gstate_d;
  logic play, load;
  logic [NUM_HOLES-1:0] hit_v, esc_v;
  logic [CNT_W-1:0] hit_cnt, esc_cnt;
  logic [SCORE_W-1:0] score_d;
`ifdef MOLE_WHIFF_PENALTY_EN
  logic [NUM_HOLES-1:0] whiff_v;
  logic [CNT_W-1:0] whiff_cnt;
`endif

  genvar i;
  for (i = 0; i < NUM_HOLES; i++) begin : g_lane
    mole_lane u_lane (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .play     (play),
      .load     (load),
      .ctrl     (ctrl[i]),
      .key      (key[i]),
      .hit      (hit_v[i]),
      .escape   (esc_v[i]),
`ifdef MOLE_WHIFF_PENALTY_EN
      .whiff    (whiff_v[i]),
`endif
      .visible  (visible[i])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) gstate <= G_IDLE;
    else         gstate <= gstate_d;
  end

  always_comb begin
    gstate_d = gstate;
    case (gstate)
      G_IDLE, G_OVER: if (start) gstate_d = G_PLAY;
      G_PLAY:         if (tick && time_left == 8'd1) gstate_d = G_OVER;
      default:        gstate_d = G_IDLE;
    endcase
  end

  always_comb begin
    play      = (gstate == G_PLAY);
    load      = start & (gstate != G_PLAY);
    playing   = play;
    game_over = (gstate == G_OVER);
  end

  always_comb begin
    hit_cnt = '0;
    esc_cnt = '0;
`ifdef MOLE_WHIFF_PENALTY_EN
    whiff_cnt = '0;
`endif
    for (int unsigned n = 0; n < NUM_HOLES; n++) begin
      hit_cnt = hit_cnt + CNT_W'(hit_v[n]);
      esc_cnt = esc_cnt + CNT_W'(esc_v[n]);
`ifdef MOLE_WHIFF_PENALTY_EN
      whiff_cnt = whiff_cnt + CNT_W'(whiff_v[n]);
`endif
    end
  end

`ifdef MOLE_WHIFF_PENALTY_EN
  // Net change may go negative; clamp into [0, SCORE_MAX].
  always_comb begin
    int sum;
    sum = int'(score) + int'(hit_cnt) - int'(whiff_cnt);
    if (sum < 0)                    score_d = '0;
    else if (sum > int'(SCORE_MAX)) score_d = '1;
    else                            score_d = SCORE_W'(sum);
  end
`else
  assign score_d = SCORE_W'(sat_add(32'(score), 32'(hit_cnt), SCORE_MAX));
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      score     <= '0;
      misses    <= '0;
      time_left <= '0;
      hit_pulse <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      if (load) begin
        score     <= '0;
        misses    <= '0;
        time_left <= 8'(GAME_SECONDS);
      end else if (play) begin
        score     <= score_d;
        misses    <= SCORE_W'(sat_add(32'(misses), 32'(esc_cnt), SCORE_MAX));
        hit_pulse <= (hit_cnt != '0);
        if (tick) time_left <= time_left - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mole_hit_scorer.sv
// Directed plus randomized bench for mole_hit_scorer against a cycle-level game model.
module tb_mole_hit_scorer;

  localparam int G    = 60;
  localparam int MAXS = 255;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0, tick = 1'b0, start = 1'b0;
  logic [7:0] ctrl = '0, key = '0;
  logic [7:0] visible, score, misses, time_left;
  logic       playing, game_over, hit_pulse;

  mole_hit_scorer #(.NUM_HOLES(8), .SCORE_W(8), .GAME_SECONDS(G)) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .tick      (tick),
    .start     (start),
    .ctrl      (ctrl),
    .key       (key),
    .visible   (visible),
    .score     (score),
    .misses    (misses),
    .time_left (time_left),
    .playing   (playing),
    .game_over (game_over),
    .hit_pulse (hit_pulse)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;

  // Game model: phase 0 idle, 1 playing, 2 over; per hole a mole is either
  // "showing" (counts when it leaves), "whacked" (hidden until ctrl drops), or absent.
  int         m_phase, m_score, m_miss, m_time;
  bit         m_hp;
  bit         m_show[8], m_whk[8];
  logic [7:0] kh[3];  // key samples taken at the last three edges, newest first

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_score = 0; m_miss = 0; m_time = 0; m_hp = 0;
    for (int i = 0; i < 8; i++) begin m_show[i] = 0; m_whk[i] = 0; end
    for (int i = 0; i < 3; i++) kh[i] = '0;
  endtask

  task automatic step(input bit rn, input bit tk, input bit st,
                      input logic [7:0] c, input logic [7:0] k);
    logic [7:0] press, vis_e, vmask;
    int hits, escs, whiffs, s;
    bit play, ld, h;
    resetn = rn; tick = tk; start = st; ctrl = c; key = k;
    #1;
    press = kh[1] & ~kh[2];
    play  = (m_phase == 1);
    for (int i = 0; i < 8; i++) begin
      vis_e[i] = m_show[i] | (!m_whk[i] & c[i]);
      vmask[i] = !(m_show[i] && !c[i]);  // falling-edge cycle of a showing mole left unchecked
    end
    chk("visible", 32'(visible & vmask), 32'(vis_e & vmask));
    @(posedge CLOCK_50);
    if (!rn) begin
      model_reset();
    end else begin
      ld = (m_phase != 1) && st;
      hits = 0; escs = 0; whiffs = 0;
      for (int i = 0; i < 8; i++) begin
        if (ld) begin
          m_show[i] = c[i]; m_whk[i] = 0;
        end else begin
          h = m_show[i] && press[i] && play;
          if (h) hits++;
          else if (m_show[i] && !c[i] && play) escs++;
          if (play && !m_show[i] && !m_whk[i] && !c[i] && press[i]) whiffs++;
          if (m_show[i]) begin
            if (h || !c[i]) begin m_show[i] = 0; m_whk[i] = h && c[i]; end
          end else if (m_whk[i]) m_whk[i] = c[i];
          else m_show[i] = c[i];
        end
      end
      if (ld) begin
        m_phase = 1; m_score = 0; m_miss = 0; m_time = G; m_hp = 0;
      end else if (play) begin
`ifdef MOLE_WHIFF_PENALTY_EN
        s = m_score + hits - whiffs;
`else
        s = m_score + hits;
`endif
        m_score = (s < 0) ? 0 : (s > MAXS ? MAXS : s);
        m_miss  = (m_miss + escs > MAXS) ? MAXS : m_miss + escs;
        m_hp    = (hits > 0);
        if (tk) begin
          m_time--;
          if (m_time == 0) m_phase = 2;
        end
      end else m_hp = 0;
      kh[2] = kh[1]; kh[1] = kh[0]; kh[0] = k;
    end
    #1;
    chk("score", 32'(score), 32'(m_score));
    chk("misses", 32'(misses), 32'(m_miss));
    chk("time_left", 32'(time_left), 32'(m_time));
    chk("playing", 32'(playing), 32'(m_phase == 1));
    chk("game_over", 32'(game_over), 32'(m_phase == 2));
    chk("hit_pulse", 32'(hit_pulse), 32'(m_hp));
  endtask

  // Raise moles m, press them, release: score changes at the fourth step.
  task automatic hit_round(input logic [7:0] m);
    step(1, 0, 0, m, '0);
    step(1, 0, 0, m, m);
    step(1, 0, 0, m, m);
    step(1, 0, 0, m, m);
    chk("round_pulse", 32'(hit_pulse), 32'(1));
    step(1, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rc, rk, tm;
    model_reset();
    repeat (3) step(0, 0, 0, '0, '0);
    chk("rst_score", 32'(score), 0);
    chk("rst_visible", 32'(visible), 0);
    chk("rst_time", 32'(time_left), 0);
    step(1, 0, 0, '0, '0);
    step(1, 0, 1, '0, '0);
    chk("start_time", 32'(time_left), 60);
    chk("start_play", 32'(playing), 1);

    step(1, 0, 0, 8'h08, '0);
    step(1, 0, 0, 8'h08, 8'h08);
    step(1, 0, 0, 8'h08, 8'h08);
    chk("hit_early", 32'(score), 0);
    step(1, 0, 0, 8'h08, 8'h08);
    chk("hit_score", 32'(score), 1);
    chk("hit_pulse1", 32'(hit_pulse), 1);
    chk("hit_vis3", 32'(visible[3]), 0);
    repeat (4) step(1, 0, 0, 8'h08, 8'h08);
    chk("hold_score", 32'(score), 1);
    repeat (2) step(1, 0, 0, '0, 8'h08);
    step(1, 0, 0, '0, '0);
    chk("whack_nomiss", 32'(misses), 0);

    repeat (20) step(1, 0, 0, 8'h20, '0);
    step(1, 0, 0, '0, '0);
    chk("escape_miss", 32'(misses), 1);

    step(1, 0, 0, 8'h04, '0);
    step(1, 0, 0, 8'h04, 8'h04);
    step(1, 0, 0, 8'h04, 8'h04);
    step(1, 0, 0, '0, 8'h04);
    chk("race_score", 32'(score), 2);
    chk("race_miss", 32'(misses), 1);
    step(1, 0, 0, '0, '0);

    for (int t = 1; t <= G; t++) begin
      step(1, 1, 0, '0, '0);
      if (t == G - 1) chk("time_last", 32'(time_left), 1);
      if (t < G) step(1, 0, 1, '0, '0);  // start ignored while playing
    end
    chk("over_flag", 32'(game_over), 1);
    chk("over_time", 32'(time_left), 0);
    repeat (5) step(1, 0, 0, 8'h20, '0);
    step(1, 0, 0, '0, '0);
    chk("over_miss", 32'(misses), 1);
    chk("over_score", 32'(score), 2);

    rc = '0; rk = '0;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 8; b++) begin
        tm = rc; tm[b] = tm[b] ^ ($urandom_range(7) == 0); rc = tm;
        tm = rk; tm[b] = tm[b] ^ ($urandom_range(5) == 0); rk = tm;
      end
      step(1, $urandom_range(3) == 0, $urandom_range(15) == 0, rc, rk);
    end

    step(0, 0, 0, '0, '0);
    step(1, 0, 1, '0, '0);
    for (int r = 0; r < 31; r++) hit_round(8'hFF);
    chk("sat_248", 32'(score), 248);
    hit_round(8'h03);
    chk("sat_250", 32'(score), 250);
    hit_round(8'hFF);
    chk("sat_255", 32'(score), 255);

    step(1, 1, 0, 8'h11, '0);
    step(0, 0, 0, '0, '0);
    chk("mid_rst_score", 32'(score), 0);
    chk("mid_rst_play", 32'(playing), 0);
    chk("mid_rst_time", 32'(time_left), 0);
    chk("mid_rst_vis", 32'(visible), 0);

    step(1, 0, 1, '0, '0);
    step(1, 0, 0, '0, 8'h01);
    step(1, 0, 0, '0, 8'h01);
    step(1, 0, 0, '0, 8'h01);
    step(1, 0, 0, '0, '0);
    chk("whiff_floor", 32'(score), 0);
    step(1, 0, 0, '0, '0);
    hit_round(8'h07);
    chk("whiff_pre", 32'(score), 3);
    step(1, 0, 0, 8'h01, '0);
    step(1, 0, 0, 8'h01, 8'h03);
    step(1, 0, 0, 8'h01, 8'h03);
    step(1, 0, 0, 8'h01, 8'h03);
`ifdef MOLE_WHIFF_PENALTY_EN
    chk("whiff_net", 32'(score), 3);
`else
    chk("whiff_net", 32'(score), 4);
`endif
    chk("whiff_pulse", 32'(hit_pulse), 1);
    step(1, 0, 0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
